vscale_mem_arbiter: RTL and testbench
=====================================

// Module: vscale_mem_arbiter
// PURPOSE
//  Shares one memory port between the core's instruction-fetch (imem) and data (dmem) sides.
//  Sits between the vscale pipeline (IF/WB stall logic driven by imem_wait/dmem_wait) and the memory.
//  One transaction is outstanding at a time. A new request may issue in the cycle its predecessor's response returns.
//  Priority: dmem first, with an anti-starvation streak counter that protects fetch.
// PARAMETERS
//  ADDR_WIDTH     32  byte address width
//  XLEN           32  data width
//  MAX_D_STREAK   4   consecutive dmem grants allowed while imem pending; range 1..15
// PORTS
//  clk                 in   1           clock
//  reset               in   1           synchronous, active-high
//  imem_req            in   1           fetch request valid; held until !imem_wait
//  imem_addr           in   ADDR_WIDTH  fetch address
//  imem_wait           out  1           fetch not complete this cycle
//  imem_rdata          out  XLEN        fetch data; valid when imem_req && !imem_wait
//  imem_badmem_e       out  1           fetch bus error, qualified like imem_rdata
//  dmem_en             in   1           data request valid; held until accepted
//  dmem_wen            in   1           1 = store
//  dmem_size           in   3           funct3 size code, passed through
//  dmem_addr           in   ADDR_WIDTH  data address
//  dmem_wdata_delayed  in   XLEN        store data, presented in the cycle after acceptance
//  dmem_wait           out  1           data response not yet returned
//  dmem_rdata          out  XLEN        load data
//  dmem_badmem_e       out  1           data bus error
//  mem_req_valid       out  1           downstream request valid
//  mem_req_ready       in   1           downstream accepts when valid&&ready
//  mem_req_addr        out  ADDR_WIDTH  muxed address
//  mem_req_wen         out  1           0 for imem grants
//  mem_req_size        out  3           3'b010 (word) for imem grants
//  mem_wdata           out  XLEN        dmem_wdata_delayed while a store is outstanding, else 0
//  mem_resp_valid      in   1           response for the outstanding request
//  mem_resp_rdata      in   XLEN        response data
//  mem_resp_badmem_e   in   1           response error
// BEHAVIOUR
//  - FSM states IDLE, BUSY_I, BUSY_D. Reset -> IDLE, streak=0. All outputs 0 except imem_wait and dmem_wait, which follow the request inputs.
//  - Grant is evaluated in IDLE, or in BUSY_x in the cycle mem_resp_valid=1.
//    - dmem_en && (!imem_req || streak<MAX_D_STREAK) -> grant D.
//    - else imem_req -> grant I.
//  - mem_req_valid = grant exists. The grant is held stable (addr, wen, size) until mem_req_ready.
//  - valid&&ready -> BUSY_I or BUSY_D, with owner recorded.
//  - Response (BUSY_x && mem_resp_valid) -> route rdata/badmem_e to the owner and deassert that side's wait for the cycle.
//    - Next state = new grant accepted ? BUSY_y : IDLE.
//  - Waits:
//    - imem_wait = imem_req && !(BUSY_I && mem_resp_valid).
//    - dmem_wait = dmem_en_pending && !(BUSY_D && mem_resp_valid). dmem_en_pending means dmem_en, or a dmem transaction outstanding.
//  - Minimum latency is 1 cycle: accept in N, response in N+1.
//  - Streak counter:
//    - D grant accepted while imem_req=1: streak++, saturating at MAX_D_STREAK.
//    - I grant accepted, or imem_req=0: streak=0.
//  - mem_resp_valid in IDLE is ignored: no routing, no state change.
//  - Reset mid-transaction returns to IDLE, drops ownership and ignores any late response.
//  - The core must not change imem_addr while imem_wait=1. A redirect issues only after the current fetch completes.
// CONFIGURATION
//  - VSCALE_MEM_ARB_PERF_EN defined: adds outputs perf_conflict_cycles [31:0] and perf_imem_stall_cycles [31:0].
//    - conflict: cycles with imem_req && dmem_en both pending in a grant cycle.
//    - imem stall: cycles with imem_wait=1.
//    - Both reset to 0 and wrap modulo 2^32.
//  - Undefined: the ports and counters are absent. Functional behaviour is identical.
// STRUCTURE
//  - Shared header vscale_mem_arb_constants.vh:
//    - ARB_STATE_WIDTH=2, ARB_IDLE=0, ARB_BUSY_I=1, ARB_BUSY_D=2.
//    - MEM_SIZE_WORD=3'b010.
//  - One sub-module, vscale_arb_streak_ctr: saturating counter with inc/clr inputs and an at_max output.
//  - Grant mux and FSM stay in this file.
// TESTING
//  1. imem_req only, addr 0x200, ready=1, resp in next cycle with 0x00000013.
//     -> imem_rdata=0x13, imem_wait low exactly 1 cycle, streak=0.
//  2. imem_req and dmem_en (load 0x1000) in the same cycle.
//     -> D granted first, I granted in D's response cycle. No idle cycle between them.
//  3. imem_req held, dmem_en held continuously, MAX_D_STREAK=4.
//     -> grant sequence D,D,D,D,I,D...
//  4. Store to 0x1004 with wdata_delayed 0xDEADBEEF, ready held low 3 cycles.
//     -> mem_req_addr stable all 3 cycles, mem_wdata=0xDEADBEEF while BUSY_D.
//  5. Load response with mem_resp_badmem_e=1.
//     -> dmem_badmem_e=1 for 1 cycle, imem_badmem_e stays 0.
//  6. reset asserted in BUSY_I, late mem_resp_valid in the following cycle.
//     -> state IDLE, no rdata routed, imem_wait=imem_req.

Source files
------------

// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared constants and state encoding for the vscale memory arbiter.
package vscale_mem_arbiter_pkg;

  localparam int ARB_STATE_WIDTH = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  // Instruction fetches are always full-word reads.
  localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

endpackage

// File: rtl/vscale_mem_arbiter_if.sv
// Downstream memory port shared by fetch and data traffic.
// Handshake: a request transfers in any cycle where mem_req_valid && mem_req_ready;
// while valid is high and ready is low, addr/wen/size are held stable. One request
// is outstanding at a time and its response is the cycle with mem_resp_valid=1.
interface vscale_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int XLEN       = 32
) ();
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_wen;
  logic [2:0]            mem_req_size;
  logic [XLEN-1:0]       mem_wdata;
  logic                  mem_resp_valid;
  logic [XLEN-1:0]       mem_resp_rdata;
  logic                  mem_resp_badmem_e;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_size, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_badmem_e
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_size, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_badmem_e
  );
endinterface

// File: rtl/vscale_arb_streak_ctr.sv
// Saturating count of back-to-back data grants taken while a fetch waits.
module vscale_arb_streak_ctr #(
  parameter int MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic       at_max,
  output logic [3:0] count
);
  localparam logic [3:0] MAX_C = 4'(MAX);

  // Clear wins over increment; the count sticks at MAX.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= 4'd0;
    end else if (inc && (count < MAX_C)) begin
      count <= count + 4'd1;
    end
  end

  assign at_max = (count == MAX_C);
endmodule

// File: rtl/vscale_mem_arbiter.sv
// vscale_mem_arbiter: one memory port shared by fetch (imem) and data (dmem).
// Data has priority, but after MAX_D_STREAK consecutive data grants with a fetch
// pending, the fetch is granted. Define VSCALE_MEM_ARB_PERF_EN to add the
// perf_conflict_cycles / perf_imem_stall_cycles counters.
module vscale_mem_arbiter
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int XLEN         = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_req,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_wait,
  output logic [XLEN-1:0]       imem_rdata,
  output logic                  imem_badmem_e,
  input  logic                  dmem_en,
  input  logic                  dmem_wen,
  input  logic [2:0]            dmem_size,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [XLEN-1:0]       dmem_wdata_delayed,
  output logic                  dmem_wait,
  output logic [XLEN-1:0]       dmem_rdata,
  output logic                  dmem_badmem_e,
  vscale_mem_arbiter_if.master  mem,
  output arb_state_e            arb_state,
  output logic [3:0]            d_streak
`ifdef VSCALE_MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_conflict_cycles,
  output logic [31:0]           perf_imem_stall_cycles
`endif
);

  arb_state_e state_q, state_d;
  logic hold_valid_q, hold_d_q, d_wen_q;
  logic resp, resp_i, resp_d, grant_eval, d_pref, grant_d, grant_i, accept;
  logic at_max;

  // A response only counts while a transaction is outstanding and not in reset.
  assign resp   = !reset && (state_q != ARB_IDLE) && mem.mem_resp_valid;
  assign resp_i = resp && (state_q == ARB_BUSY_I);
  assign resp_d = resp && (state_q == ARB_BUSY_D);

  // Grants are decided when idle or in the response cycle; a stalled grant is
  // replayed from hold_* so the request stays stable until accepted.
  assign grant_eval = !reset && ((state_q == ARB_IDLE) || resp);
  assign d_pref     = dmem_en && (!imem_req || !at_max);
  assign grant_d    = grant_eval && (hold_valid_q ? hold_d_q : d_pref);
  assign grant_i    = grant_eval && (hold_valid_q ? !hold_d_q : (!d_pref && imem_req));
  assign accept     = (grant_d || grant_i) && mem.mem_req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Next state: at a grant point go busy on accept, otherwise fall back to idle.
  always_comb begin
    state_d = state_q;
    if (grant_eval) begin
      if (accept) state_d = grant_d ? ARB_BUSY_D : ARB_BUSY_I;
      else        state_d = ARB_IDLE;
    end
  end

  // Remember a grant that was offered but not yet accepted, and the store flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_d_q     <= 1'b0;
      d_wen_q      <= 1'b0;
    end else begin
      if (accept) begin
        hold_valid_q <= 1'b0;
        d_wen_q      <= grant_d && dmem_wen;
      end else if (grant_d || grant_i) begin
        hold_valid_q <= 1'b1;
        hold_d_q     <= grant_d;
      end
    end
  end

  vscale_arb_streak_ctr #(.MAX(MAX_D_STREAK)) u_streak (
    .clk    (clk),
    .reset  (reset),
    .inc    (accept && grant_d && imem_req),
    .clr    (!imem_req || (accept && grant_i)),
    .at_max (at_max),
    .count  (d_streak)
  );

  // Request mux and response routing.
  always_comb begin
    mem.mem_req_valid = grant_d || grant_i;
    mem.mem_req_addr  = grant_d ? dmem_addr : (grant_i ? imem_addr : '0);
    mem.mem_req_wen   = grant_d && dmem_wen;
    mem.mem_req_size  = grant_d ? dmem_size : (grant_i ? MEM_SIZE_WORD : 3'b000);
    mem.mem_wdata     = (!reset && (state_q == ARB_BUSY_D) && d_wen_q) ? dmem_wdata_delayed : '0;
    imem_wait         = imem_req && !resp_i;
    imem_rdata        = resp_i ? mem.mem_resp_rdata : '0;
    imem_badmem_e     = resp_i && mem.mem_resp_badmem_e;
    dmem_wait         = (dmem_en || (!reset && (state_q == ARB_BUSY_D))) && !resp_d;
    dmem_rdata        = resp_d ? mem.mem_resp_rdata : '0;
    dmem_badmem_e     = resp_d && mem.mem_resp_badmem_e;
  end

  assign arb_state = state_q;

`ifdef VSCALE_MEM_ARB_PERF_EN
  // Contention and fetch-stall counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict_cycles   <= 32'd0;
      perf_imem_stall_cycles <= 32'd0;
    end else begin
      if (grant_eval && imem_req && dmem_en) perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
      if (imem_wait) perf_imem_stall_cycles <= perf_imem_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Bench for vscale_mem_arbiter: reset/grant vector table, then scoreboarded
// multi-cycle sequences against a one-cycle-latency memory model.
module tb_vscale_mem_arbiter;
  import vscale_mem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        imem_req, imem_wait, imem_badmem_e;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_en, dmem_wen, dmem_wait, dmem_badmem_e;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wdata_delayed, dmem_rdata;
  arb_state_e  arb_state;
  logic [3:0]  d_streak;
`ifdef VSCALE_MEM_ARB_PERF_EN
  logic [31:0] perf_conflict_cycles, perf_imem_stall_cycles;
`endif

  vscale_mem_arbiter_if #(.ADDR_WIDTH(32), .XLEN(32)) mem_bus ();

  vscale_mem_arbiter #(.ADDR_WIDTH(32), .XLEN(32), .MAX_D_STREAK(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_wait          (imem_wait),
    .imem_rdata         (imem_rdata),
    .imem_badmem_e      (imem_badmem_e),
    .dmem_en            (dmem_en),
    .dmem_wen           (dmem_wen),
    .dmem_size          (dmem_size),
    .dmem_addr          (dmem_addr),
    .dmem_wdata_delayed (dmem_wdata_delayed),
    .dmem_wait          (dmem_wait),
    .dmem_rdata         (dmem_rdata),
    .dmem_badmem_e      (dmem_badmem_e),
    .mem                (mem_bus),
    .arb_state          (arb_state),
    .d_streak           (d_streak)
`ifdef VSCALE_MEM_ARB_PERF_EN
    ,
    .perf_conflict_cycles   (perf_conflict_cycles),
    .perf_imem_stall_cycles (perf_imem_stall_cycles)
`endif
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [2:0]  size;
    logic [31:0] wdata;
  } dreq_t;

  typedef struct {
    logic        rst, ireq, den, dwen;
    logic [2:0]  dsize;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [2:0]  exp_size;
    logic        exp_iwait, exp_dwait;
  } vec_t;

  logic [31:0] i_todo_q[$];
  logic [32:0] i_exp_q[$];
  dreq_t       d_todo_q[$];
  logic [32:0] d_exp_q[$];
  logic [31:0] grant_exp_q[$];
  int          acc_cyc_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, i_done = 0, stall_cycles = 0, d_bad_cycles = 0, i_bad_cycles = 0, wdata_checks = 0;
  int ready_low_left = 0;
  logic resp_due = 1'b0, resp_is_d = 1'b0, bad_d_mode = 1'b0;
  logic d_outstanding = 1'b0, d_store_out = 1'b0, stalled = 1'b0;
  logic [31:0] resp_addr = 32'h0, wdata_hold = 32'h0, stall_addr = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Memory contents: 0x200 holds a NOP, everything else a tagged address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h200) ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
  endfunction

  // ---------------- driver: one clock of core + memory model ----------------
  task automatic run_cycle();
    dreq_t d;
    logic  resp_due_n;
    logic [32:0] e;
    d = '{addr: 32'h0, wen: 1'b0, size: 3'b000, wdata: 32'h0};
    @(negedge clk);
    imem_req  = (i_todo_q.size() > 0);
    imem_addr = imem_req ? i_todo_q[0] : 32'h0;
    if (d_todo_q.size() > 0) d = d_todo_q[0];
    dmem_en   = (d_todo_q.size() > 0);
    dmem_wen  = d.wen;
    dmem_size = d.size;
    dmem_addr = d.addr;
    dmem_wdata_delayed = wdata_hold;
    mem_bus.mem_req_ready     = (ready_low_left == 0);
    mem_bus.mem_resp_valid    = resp_due;
    mem_bus.mem_resp_rdata    = resp_due ? mem_f(resp_addr) : 32'h0;
    mem_bus.mem_resp_badmem_e = resp_due && resp_is_d && bad_d_mode;
    #2;
    cyc++;
    if (dmem_badmem_e) d_bad_cycles++;
    if (imem_badmem_e) i_bad_cycles++;
    if (d_store_out) begin
      wdata_checks++;
      check("mem_wdata", 64'(mem_bus.mem_wdata), 64'(wdata_hold));
    end
    if (imem_req && !imem_wait) begin
      i_done++;
      if (i_exp_q.size() == 0) fail_event("imem_spurious_resp");
      else begin
        e = i_exp_q.pop_front();
        check("imem_resp", 64'({imem_badmem_e, imem_rdata}), 64'(e));
      end
      void'(i_todo_q.pop_front());
    end
    if (d_outstanding && !dmem_wait) begin
      if (d_exp_q.size() == 0) fail_event("dmem_spurious_resp");
      else begin
        e = d_exp_q.pop_front();
        check("dmem_resp", 64'({dmem_badmem_e, dmem_rdata}), 64'(e));
      end
      d_outstanding = 1'b0;
      d_store_out   = 1'b0;
    end
    resp_due_n = 1'b0;
    if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
      resp_due_n = 1'b1;
      resp_addr  = mem_bus.mem_req_addr;
      resp_is_d  = dmem_en && (mem_bus.mem_req_addr == dmem_addr);
      acc_cyc_q.push_back(cyc);
      if (grant_exp_q.size() > 0) check("grant_addr", 64'(mem_bus.mem_req_addr), 64'(grant_exp_q.pop_front()));
      if (resp_is_d) begin
        check("d_req_attr", 64'({mem_bus.mem_req_wen, mem_bus.mem_req_size}), 64'({d.wen, d.size}));
        d_outstanding = 1'b1;
        d_store_out   = d.wen;
        wdata_hold    = d.wdata;
        void'(d_todo_q.pop_front());
      end else begin
        check("i_req_attr", 64'({mem_bus.mem_req_wen, mem_bus.mem_req_size}), 64'({1'b0, 3'b010}));
      end
      stalled = 1'b0;
    end else if (mem_bus.mem_req_valid) begin
      if (stalled) check("stall_addr_stable", 64'(mem_bus.mem_req_addr), 64'(stall_addr));
      stalled    = 1'b1;
      stall_addr = mem_bus.mem_req_addr;
      stall_cycles++;
      if (ready_low_left > 0) ready_low_left--;
    end
    resp_due = resp_due_n;
  endtask

  function automatic logic quiet();
    return (i_todo_q.size() == 0) && (d_todo_q.size() == 0) && (grant_exp_q.size() == 0) &&
           (i_exp_q.size() == 0) && (d_exp_q.size() == 0) && !d_outstanding && !resp_due &&
           (arb_state == ARB_IDLE);
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (!quiet() && (n < budget));
    if (!quiet()) fail_event("drain_timeout");
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[7];

  initial begin
    reset = 1'b1;
    imem_req = 0; imem_addr = 0; dmem_en = 0; dmem_wen = 0; dmem_size = 0;
    dmem_addr = 0; dmem_wdata_delayed = 0;
    mem_bus.mem_req_ready = 0; mem_bus.mem_resp_valid = 0;
    mem_bus.mem_resp_rdata = 0; mem_bus.mem_resp_badmem_e = 0;

    //           rst  ireq den dwen dsize   valid addr          wen  size    iw   dw
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0000_0000, 1'b0, 3'b000, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0000_0000, 1'b0, 3'b000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h0000_0200, 1'b0, 3'b010, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 32'h0000_1000, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 32'h0000_1000, 1'b1, 3'b010, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 32'h0000_1000, 1'b0, 3'b001, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 32'h0000_1000, 1'b1, 3'b000, 1'b1, 1'b1};

    repeat (2) @(negedge clk);

    // Single-cycle grant decisions from idle; a stray response must be ignored.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset     = vecs[i].rst;
      imem_req  = vecs[i].ireq;
      imem_addr = 32'h200;
      dmem_en   = vecs[i].den;
      dmem_wen  = vecs[i].dwen;
      dmem_size = vecs[i].dsize;
      dmem_addr = 32'h1000;
      mem_bus.mem_req_ready  = 1'b0;
      mem_bus.mem_resp_valid = 1'b1;
      mem_bus.mem_resp_rdata = 32'hFFFF_FFFF;
      #2;
      check($sformatf("vec%0d_valid", i), 64'(mem_bus.mem_req_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_addr", i), 64'(mem_bus.mem_req_addr), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d_wen_size", i), 64'({mem_bus.mem_req_wen, mem_bus.mem_req_size}),
            64'({vecs[i].exp_wen, vecs[i].exp_size}));
      check($sformatf("vec%0d_waits", i), 64'({imem_wait, dmem_wait}), 64'({vecs[i].exp_iwait, vecs[i].exp_dwait}));
      check($sformatf("vec%0d_rdata", i), 64'({imem_rdata, dmem_rdata}), 64'h0);
      check($sformatf("vec%0d_state", i), 64'(arb_state), 64'(ARB_IDLE));
    end
    @(negedge clk);
    reset = 1'b1;
    imem_req = 0; dmem_en = 0; dmem_wen = 0; dmem_size = 0;
    mem_bus.mem_resp_valid = 0; mem_bus.mem_resp_rdata = 0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("reset_streak", 64'(d_streak), 64'h0);

    // 1: lone fetch, one-cycle latency.
    i_done = 0;
    i_todo_q.push_back(32'h200); i_exp_q.push_back({1'b0, 32'h0000_0013});
    drain(20);
    check("t1_wait_low_cycles", 64'(i_done), 64'd1);
    check("t1_streak", 64'(d_streak), 64'h0);

    // 2: simultaneous fetch and load; data first, fetch in the data response cycle.
    acc_cyc_q.delete();
    i_todo_q.push_back(32'h200); i_exp_q.push_back({1'b0, 32'h0000_0013});
    d_todo_q.push_back('{addr: 32'h1000, wen: 1'b0, size: 3'b010, wdata: 32'h0});
    d_exp_q.push_back({1'b0, mem_f(32'h1000)});
    grant_exp_q.push_back(32'h1000); grant_exp_q.push_back(32'h200);
    drain(20);
    if (acc_cyc_q.size() < 2) fail_event("t2_missing_grants");
    else check("t2_back_to_back", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd1);

    // 3: continuous data traffic with a waiting fetch: D,D,D,D,I,D,D.
    for (int k = 0; k < 6; k++) begin
      d_todo_q.push_back('{addr: 32'h1000 + 32'(4 * k), wen: 1'b0, size: 3'(k % 3), wdata: 32'h0});
      d_exp_q.push_back({1'b0, mem_f(32'h1000 + 32'(4 * k))});
    end
    i_todo_q.push_back(32'h204); i_exp_q.push_back({1'b0, mem_f(32'h204)});
    grant_exp_q.push_back(32'h1000); grant_exp_q.push_back(32'h1004);
    grant_exp_q.push_back(32'h1008); grant_exp_q.push_back(32'h100C);
    grant_exp_q.push_back(32'h204);
    grant_exp_q.push_back(32'h1010); grant_exp_q.push_back(32'h1014);
    drain(40);

    // 4: store stalled by ready low for 3 cycles.
    stall_cycles = 0; wdata_checks = 0; ready_low_left = 3;
    d_todo_q.push_back('{addr: 32'h1004, wen: 1'b1, size: 3'b010, wdata: 32'hDEAD_BEEF});
    d_exp_q.push_back({1'b0, mem_f(32'h1004)});
    grant_exp_q.push_back(32'h1004);
    drain(20);
    check("t4_stall_cycles", 64'(stall_cycles), 64'd3);
    check("t4_wdata_seen", 64'(wdata_checks), 64'd1);
    check("t4_wdata_value", 64'(wdata_hold), 64'hDEAD_BEEF);

    // 5: load error routed to data side only.
    d_bad_cycles = 0; i_bad_cycles = 0; bad_d_mode = 1'b1;
    d_todo_q.push_back('{addr: 32'h1008, wen: 1'b0, size: 3'b010, wdata: 32'h0});
    d_exp_q.push_back({1'b1, mem_f(32'h1008)});
    i_todo_q.push_back(32'h208); i_exp_q.push_back({1'b0, mem_f(32'h208)});
    drain(20);
    bad_d_mode = 1'b0;
    check("t5_dmem_bad_cycles", 64'(d_bad_cycles), 64'd1);
    check("t5_imem_bad_cycles", 64'(i_bad_cycles), 64'd0);

    // 6: reset while a fetch is outstanding, then a late response.
    @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h20C; dmem_en = 1'b0;
    mem_bus.mem_req_ready = 1'b1; mem_bus.mem_resp_valid = 1'b0;
    #2;
    check("t6_req_valid", 64'(mem_bus.mem_req_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1; mem_bus.mem_req_ready = 1'b0;
    #2;
    check("t6_busy_before_reset", 64'(arb_state), 64'(ARB_BUSY_I));
    @(negedge clk);
    reset = 1'b0;
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_rdata = 32'h1111_1111;
    #2;
    check("t6_state_idle", 64'(arb_state), 64'(ARB_IDLE));
    check("t6_no_rdata", 64'({imem_badmem_e, imem_rdata}), 64'h0);
    check("t6_imem_wait", 64'(imem_wait), 64'd1);
    @(negedge clk);
    reset = 1'b1; imem_req = 1'b0; mem_bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("t6_final_idle", 64'(arb_state), 64'(ARB_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
